proc_io_hub: RTL and testbench

Peripheral-side responder for a `proc_fx` core's I/O bus, the counterpart of the processor's decoded `req_in`/`out_en` strobes. It serves processor input reads from per-port input FIFOs filled by external valid/ready producers. It captures processor output writes into per-port output FIFOs drained by external valid/ready consumers. In the quad-core build, one hub sits beside each core and links it to neighbouring cores and top-level I/O.

---
 rtl/proc_io_pkg.sv | 15 +
 rtl/io_fifo.sv | 56 +++++
 rtl/proc_io_hub.sv | 90 +++++++++
 tb/tb_proc_io_hub.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_io_pkg.sv
// Shared definitions for the processor I/O hub: default FIFO depth and the
// lowest-set-bit strobe select used by hub and address-decoder users.
package proc_io_pkg;

  localparam int FDEPTH_DEF = 4;
  localparam int LSB_W      = 32;

  // True when bit idx is the lowest set bit of v; turns any strobe vector one-hot.
  function automatic logic lsb_onehot(input logic [LSB_W-1:0] v, input int idx);
    logic [LSB_W-1:0] below;
    below = (LSB_W'(1) << idx) - LSB_W'(1);
    return v[idx] && ((v & below) == '0);
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Power-of-two FIFO with a registered occupancy count; head reads as zero when
// empty so downstream data never exposes stale storage.
module io_fifo
  import proc_io_pkg::*;
#(
  parameter int NUBITS = 32,
  parameter int FDEPTH = FDEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [NUBITS-1:0] i_data,
  output logic [NUBITS-1:0] o_head,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(FDEPTH);
  localparam int CW = AW + 1;

  logic [NUBITS-1:0] r_mem [FDEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CW'(FDEPTH));
  assign o_empty = (r_count == '0);
  // Full/empty come from the pre-edge count, so a same-cycle pop never makes room for a push.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/proc_io_hub.sv
// Processor-side I/O responder: input FIFOs feed zero-latency reads, output
// FIFOs capture writes for valid/ready consumers, with sticky error flags.
module proc_io_hub
  import proc_io_pkg::*;
#(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = FDEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUIOIN-1:0]        req_in,
  output logic signed [NUBITS-1:0] io_in,
  input  logic [NUIOOU-1:0]        out_en,
  input  logic signed [NUBITS-1:0] io_out,
  input  logic [NUIOIN*NUBITS-1:0] src_data,
  input  logic [NUIOIN-1:0]        src_valid,
  output logic [NUIOIN-1:0]        src_ready,
  output logic [NUIOOU*NUBITS-1:0] snk_data,
  output logic [NUIOOU-1:0]        snk_valid,
  input  logic [NUIOOU-1:0]        snk_ready,
  output logic [NUIOIN-1:0]        err_udf,
  output logic [NUIOOU-1:0]        err_ovf
);

  logic [NUIOIN-1:0]        w_rd_sel;
  logic [NUIOIN-1:0]        w_in_full;
  logic [NUIOIN-1:0]        w_in_empty;
  logic [NUIOIN*NUBITS-1:0] w_in_head;
  logic [NUIOOU-1:0]        w_wr_sel;
  logic [NUIOOU-1:0]        w_out_full;
  logic [NUIOOU-1:0]        w_out_empty;
  logic [NUBITS-1:0]        w_io_in;
  logic [NUIOIN-1:0]        r_err_udf;
  logic [NUIOOU-1:0]        r_err_ovf;

  for (genvar gi = 0; gi < NUIOIN; gi++) begin : g_in
    assign w_rd_sel[gi] = lsb_onehot(LSB_W'(req_in), gi);
    io_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (src_valid[gi] && !w_in_full[gi]),
      .i_pop   (w_rd_sel[gi]),
      .i_data  (src_data[gi*NUBITS +: NUBITS]),
      .o_head  (w_in_head[gi*NUBITS +: NUBITS]),
      .o_full  (w_in_full[gi]),
      .o_empty (w_in_empty[gi])
    );
  end

  for (genvar gi = 0; gi < NUIOOU; gi++) begin : g_out
    assign w_wr_sel[gi] = lsb_onehot(LSB_W'(out_en), gi);
    io_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_wr_sel[gi]),
      .i_pop   (snk_ready[gi]),
      .i_data  (io_out),
      .o_head  (snk_data[gi*NUBITS +: NUBITS]),
      .o_full  (w_out_full[gi]),
      .o_empty (w_out_empty[gi])
    );
  end

  // Empty heads read as zero, so OR-ing the selected head also covers underflow.
  always_comb begin
    w_io_in = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (w_rd_sel[k]) w_io_in = w_io_in | w_in_head[k*NUBITS +: NUBITS];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_udf <= '0;
      r_err_ovf <= '0;
    end else begin
      r_err_udf <= r_err_udf | (w_rd_sel & w_in_empty);
      r_err_ovf <= r_err_ovf | (w_wr_sel & w_out_full);
    end
  end

  assign io_in     = w_io_in;
  assign src_ready = ~w_in_full;
  assign snk_valid = ~w_out_empty;
  assign err_udf   = r_err_udf;
  assign err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_proc_io_hub.sv
// Directed bench for proc_io_hub: queue-based reference model compared every
// cycle, plus hand-computed expectations at each step of the scenario.
module tb_proc_io_hub;

  localparam int NUBITS = 32;
  localparam int NUIOIN = 2;
  localparam int NUIOOU = 2;
  localparam int FDEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUIOIN-1:0]        req_in = '0;
  logic signed [NUBITS-1:0] io_in;
  logic [NUIOOU-1:0]        out_en = '0;
  logic signed [NUBITS-1:0] io_out = '0;
  logic [NUIOIN*NUBITS-1:0] src_data = '0;
  logic [NUIOIN-1:0]        src_valid = '0;
  logic [NUIOIN-1:0]        src_ready;
  logic [NUIOOU*NUBITS-1:0] snk_data;
  logic [NUIOOU-1:0]        snk_valid;
  logic [NUIOOU-1:0]        snk_ready = '0;
  logic [NUIOIN-1:0]        err_udf;
  logic [NUIOOU-1:0]        err_ovf;

  proc_io_hub #(.NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .io_in     (io_in),
    .out_en    (out_en),
    .io_out    (io_out),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .snk_data  (snk_data),
    .snk_valid (snk_valid),
    .snk_ready (snk_ready),
    .err_udf   (err_udf),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  typedef logic [NUBITS-1:0] word_q_t[$];
  word_q_t q_in  [NUIOIN];
  word_q_t q_out [NUIOOU];
  logic [NUIOIN-1:0] exp_udf = '0;
  logic [NUIOOU-1:0] exp_ovf = '0;
  int sz_in  [NUIOIN];
  int sz_out [NUIOOU];
  int rsel;
  int wsel;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic hchk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk(nm, act, exp);
    $display("txn %-14s act=%h exp=%h", nm, act, exp);
  endtask

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [NUBITS-1:0] exp_io_in();
    int s;
    s = lowest(32'(req_in));
    if (s < 0 || q_in[s].size() == 0) return '0;
    return q_in[s][0];
  endfunction

  function automatic logic [NUIOIN-1:0] exp_src_ready();
    logic [NUIOIN-1:0] r;
    for (int k = 0; k < NUIOIN; k++) r[k] = (q_in[k].size() < FDEPTH);
    return r;
  endfunction

  function automatic logic [NUIOOU-1:0] exp_snk_valid();
    logic [NUIOOU-1:0] r;
    for (int k = 0; k < NUIOOU; k++) r[k] = (q_out[k].size() != 0);
    return r;
  endfunction

  function automatic logic [NUIOOU*NUBITS-1:0] exp_snk_data();
    logic [NUIOOU*NUBITS-1:0] r;
    r = '0;
    for (int k = 0; k < NUIOOU; k++)
      if (q_out[k].size() != 0) r[k*NUBITS +: NUBITS] = q_out[k][0];
    return r;
  endfunction

  // Reference model: decisions use pre-edge occupancy, then queues are updated.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUIOIN; k++) q_in[k].delete();
      for (int k = 0; k < NUIOOU; k++) q_out[k].delete();
      exp_udf <= '0;
      exp_ovf <= '0;
    end else begin
      rsel = lowest(32'(req_in));
      wsel = lowest(32'(out_en));
      for (int k = 0; k < NUIOIN; k++) sz_in[k] = q_in[k].size();
      for (int k = 0; k < NUIOOU; k++) sz_out[k] = q_out[k].size();
      for (int k = 0; k < NUIOIN; k++) begin
        if (rsel == k) begin
          if (sz_in[k] > 0) void'(q_in[k].pop_front());
          else exp_udf[k] <= 1'b1;
        end
        if (src_valid[k] && sz_in[k] < FDEPTH) q_in[k].push_back(src_data[k*NUBITS +: NUBITS]);
      end
      for (int k = 0; k < NUIOOU; k++) begin
        if (snk_ready[k] && sz_out[k] > 0) void'(q_out[k].pop_front());
        if (wsel == k) begin
          if (sz_out[k] < FDEPTH) q_out[k].push_back(io_out);
          else exp_ovf[k] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_io_in",     64'(io_in),     64'(exp_io_in()));
      chk("m_src_ready", 64'(src_ready), 64'(exp_src_ready()));
      chk("m_snk_valid", 64'(snk_valid), 64'(exp_snk_valid()));
      chk("m_snk_data",  64'(snk_data),  64'(exp_snk_data()));
      chk("m_err_udf",   64'(err_udf),   64'(exp_udf));
      chk("m_err_ovf",   64'(err_ovf),   64'(exp_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [NUBITS-1:0] d);
    src_data[k*NUBITS +: NUBITS] = d;
  endtask

  initial begin
    step();
    step();
    chk_en = 1'b1;
    hchk("rst_src_ready", 64'(src_ready), 64'h3);
    hchk("rst_snk_valid", 64'(snk_valid), 64'h0);
    hchk("rst_io_in",     64'(io_in),     64'h0);
    rst = 1'b1;
    step();

    // Port 0 stream then three reads
    src_valid = 2'b01;
    set_src(0, 32'h11); step();
    set_src(0, 32'h22); step();
    set_src(0, 32'h33); step();
    src_valid = 2'b00;
    req_in = 2'b01; #1;
    hchk("rd0_a", 64'(io_in), 64'h11); step();
    hchk("rd0_b", 64'(io_in), 64'h22); step();
    hchk("rd0_c", 64'(io_in), 64'h33); step();
    req_in = 2'b00;

    // Port 1 fill to full, one read frees a slot for the fifth word
    src_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      set_src(1, 32'hA0 + 32'(i)); step();
    end
    set_src(1, 32'hA4); #1;
    hchk("p1_full", 64'(src_ready[1]), 64'h0);
    step();
    req_in = 2'b10; #1;
    hchk("p1_rd_head", 64'(io_in), 64'hA0);
    step();
    req_in = 2'b00;
    hchk("p1_ready", 64'(src_ready[1]), 64'h1);
    step();
    src_valid = 2'b00;
    hchk("p1_refull", 64'(src_ready[1]), 64'h0);
    req_in = 2'b10;
    for (int i = 1; i < 5; i++) begin
      #1;
      hchk("p1_drain", 64'(io_in), 64'hA0 + 64'(i));
      step();
    end
    req_in = 2'b00;

    // Underflow on empty port 0; strobe with both bits set picks port 0
    req_in = 2'b11; #1;
    hchk("udf_io_in", 64'(io_in), 64'h0);
    step();
    req_in = 2'b00;
    hchk("udf_flag", 64'(err_udf), 64'h1);
    step();
    hchk("udf_sticky", 64'(err_udf), 64'h1);
    hchk("p0_empty_rdy", 64'(src_ready), 64'h3);

    // Output overflow on port 1
    out_en = 2'b10; io_out = -32'sd5; snk_ready = 2'b00;
    for (int i = 0; i < 5; i++) step();
    out_en = 2'b00;
    hchk("ovf_flag",  64'(err_ovf),   64'h2);
    hchk("ovf_valid", 64'(snk_valid), 64'h2);
    snk_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      hchk("ovf_drain", 64'(snk_data[NUBITS +: NUBITS]), 64'hFFFF_FFFB);
      step();
    end
    hchk("ovf_empty", 64'(snk_valid), 64'h0);
    snk_ready = 2'b00;

    // Output port 0 ordering, with drain
    out_en = 2'b01;
    io_out = 32'sd7; step();
    io_out = 32'sd8; step();
    out_en = 2'b00;
    snk_ready = 2'b01;
    hchk("out0_a", 64'(snk_data[0 +: NUBITS]), 64'd7); step();
    hchk("out0_b", 64'(snk_data[0 +: NUBITS]), 64'd8); step();
    snk_ready = 2'b00;

    // Simultaneous push and pop on port 0 holding two words
    src_valid = 2'b01;
    set_src(0, 32'h51); step();
    set_src(0, 32'h52); step();
    set_src(0, 32'h53); req_in = 2'b01; #1;
    hchk("pp_head", 64'(io_in), 64'h51);
    step();
    src_valid = 2'b00;
    hchk("pp_next", 64'(io_in), 64'h52); step();
    hchk("pp_last", 64'(io_in), 64'h53); step();
    hchk("pp_empty", 64'(io_in), 64'h0);
    req_in = 2'b00; step();

    // Asynchronous reset mid-burst
    src_valid = 2'b01; set_src(0, 32'h77);
    out_en = 2'b01; io_out = 32'sd9;
    step(); step();
    req_in = 2'b01;
    #2 rst = 1'b0; #1;
    hchk("arst_io_in",  64'(io_in),     64'h0);
    hchk("arst_ready",  64'(src_ready), 64'h3);
    hchk("arst_valid",  64'(snk_valid), 64'h0);
    hchk("arst_data",   64'(snk_data),  64'h0);
    hchk("arst_errs",   64'({err_udf, err_ovf}), 64'h0);
    src_valid = 2'b00; out_en = 2'b00; req_in = 2'b00;
    step();
    rst = 1'b1;
    step();
    req_in = 2'b01; #1;
    hchk("post_rst_rd", 64'(io_in), 64'h0);
    step();
    req_in = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
